// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;
    localparam int DEF_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first; result and borrow held until the next completion.
//  state   | meaning
//  ST_IDLE | waiting for start, last result held on diff/bout
//  ST_RUN  | one bit per edge through the full subtractor, WIDTH edges total
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;

    logic bit_d;
    logic bit_bout;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // New bit enters at the MSB so bit 0 lands in place after WIDTH shifts.
                res_d = {bit_d, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bit_bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = {bit_d, res_q[WIDTH-1:1]};
                    bout_d  = bit_bout;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of the bit-serial subtractor against hand values and a 9-bit model.
module tb_serial_subtractor;
    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; the start is accepted on the next edge.
    task automatic accept(input logic [7:0] av, input logic [7:0] bv, input logic bv_in);
        start = 1'b1;
        a     = av;
        b     = bv;
        bin   = bv_in;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        bin   = ~bv_in;
    endtask

    // Counts edges from the accepting edge until done; flags diff/bout changing or busy low early.
    task automatic wait_done(input logic [7:0] held_d, input logic held_b,
                             output int n, output int unstable);
        n = 1;
        unstable = 0;
        if (busy !== 1'b1) unstable++;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (diff !== held_d || bout !== held_b || busy !== 1'b1) unstable++;
        end
        n--;
    endtask

    task automatic op_check(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic bv_in, input logic [7:0] ed, input logic eb);
        int n, u;
        accept(av, bv, bv_in);
        wait_done(diff, bout, n, u);
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_bout"}, bout, eb);
        chk({tag, "_hold"}, u, 0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int n, u, seen;
        logic [8:0] m;
        logic [7:0] ra, rb;
        logic rbi;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        op_check("v05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        op_check("v03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        op_check("v00_00b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        op_check("v80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
        op_check("vFF_FFb", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // start pulse mid-run must not disturb the operation
        accept(8'h05, 8'h03, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'hAA;
        b = 8'h11;
        bin = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (n < 40 && !done) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ign_lat", n + 3, 8);
        chk("ign_diff", diff, 8'h02);
        chk("ign_bout", bout, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("ign_idle", {busy, done, diff}, {2'b00, 8'h02});

        // reset mid-run
        accept(8'h10, 8'h01, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_out", {busy, done, diff, bout}, 11'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("mrst_nodone", seen, 0);
        op_check("post_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

        // back-to-back: new start issued in the done cycle
        accept(8'h40, 8'h20, 1'b0);
        wait_done(diff, bout, n, u);
        chk("b2b1_diff", diff, 8'h20);
        accept(8'h20, 8'h40, 1'b1);
        chk("b2b_busy", busy, 1);
        wait_done(8'h20, 1'b0, n, u);
        chk("b2b2_lat", n, 8);
        chk("b2b2_diff", {bout, diff}, 9'h1DF);
        chk("b2b2_hold", u, 0);

        // random back-to-back vectors
        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rbi = 1'($urandom);
            m = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
            accept(ra, rb, rbi);
            wait_done(diff, bout, n, u);
            if (n != 8 || u != 0) chk("rnd_timing", {n[15:0], u[15:0]}, {16'd8, 16'd0});
            chk("rnd_result", {bout, diff}, m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
